// File: rtl/progmem_loader.sv
// progmem_loader: writable 16 x 8 program store with a host load sequencer.
// It owns the store and arbitrates between the host load stream and the CPU
// fetch port. While a program is written, the CPU is held in clear. A short
// program is zero-filled, and the CPU is released after a fixed settle period.
//
// Ports:
//   CLK       rising-edge system clock
//   CLR       synchronous active-high reset
//   A / D     CPU fetch address / combinational instruction read
//   LD_START  begin a load (honoured in IDLE and RUN)
//   LD_VALID, LD_DATA, LD_LAST / LD_READY   host byte stream handshake
//   CPU_CLR   active-low CPU clear
//   BUSY      high in LOAD, FILL, RELEASE
//   LOADED    program complete and CPU released
//   COUNT     host bytes accepted in the current or last load
module progmem_loader #(
    parameter int unsigned RELEASE_CYCLES = 2,
    parameter logic [7:0]  FILL_BYTE      = 8'h00
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] A,
    output logic [7:0] D,
    input  logic       LD_START,
    input  logic       LD_VALID,
    input  logic [7:0] LD_DATA,
    input  logic       LD_LAST,
    output logic       LD_READY,
    output logic       CPU_CLR,
    output logic       BUSY,
    output logic       LOADED,
    output logic [4:0] COUNT
);

    // The release counter is preloaded on the last write and counts down to 0,
    // so RELEASE lasts exactly RELEASE_CYCLES cycles.
    localparam logic [3:0] RelInit = 4'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFill,
        StRelease,
        StRun
    } state_t;

    state_t     r_state, w_state_d;
    logic [7:0] r_mem [16];
    logic [3:0] r_ptr;
    logic [4:0] r_count;
    logic [3:0] r_rel;

    logic       w_wr_en;
    logic [7:0] w_wr_data;
    logic       w_ptr_inc;
    logic       w_cnt_inc;
    logic       w_clr_ptr;
    logic       w_rel_load;
    logic       w_rel_dec;

    always_comb begin
        w_state_d  = r_state;
        w_wr_en    = 1'b0;
        w_wr_data  = LD_DATA;
        w_ptr_inc  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_clr_ptr  = 1'b0;
        w_rel_load = 1'b0;
        w_rel_dec  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (LD_START) begin
                    w_state_d = StLoad;
                    w_clr_ptr = 1'b1;
                end
            end
            StLoad: begin
                // LD_READY is 1 throughout LOAD, so LD_VALID alone is the handshake.
                if (LD_VALID) begin
                    w_wr_en   = 1'b1;
                    w_ptr_inc = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (r_ptr == 4'd15) begin
                        w_state_d  = StRelease;
                        w_rel_load = 1'b1;
                    end else if (LD_LAST) begin
                        w_state_d = StFill;
                    end
                end
            end
            StFill: begin
                w_wr_en   = 1'b1;
                w_wr_data = FILL_BYTE;
                w_ptr_inc = 1'b1;
                if (r_ptr == 4'd15) begin
                    w_state_d  = StRelease;
                    w_rel_load = 1'b1;
                end
            end
            StRelease: begin
                if (r_rel == 4'd0) begin
                    w_state_d = StRun;
                end else begin
                    w_rel_dec = 1'b1;
                end
            end
            StRun: begin
                if (LD_START) begin
                    w_state_d = StLoad;
                    w_clr_ptr = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= StIdle;
            r_ptr   <= 4'd0;
            r_count <= 5'd0;
            r_rel   <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= FILL_BYTE;
            end
        end else begin
            r_state <= w_state_d;
            if (w_wr_en) begin
                r_mem[r_ptr] <= w_wr_data;
            end
            // After the write to address 15 the pointer wraps to 0; it is
            // cleared again at the next load start anyway.
            if (w_clr_ptr) begin
                r_ptr   <= 4'd0;
                r_count <= 5'd0;
            end else begin
                if (w_ptr_inc) r_ptr <= r_ptr + 4'd1;
                if (w_cnt_inc) r_count <= r_count + 5'd1;
            end
            if (w_rel_load) begin
                r_rel <= RelInit;
            end else if (w_rel_dec) begin
                r_rel <= r_rel - 4'd1;
            end
        end
    end

    assign D        = r_mem[A];
    assign LD_READY = (r_state == StLoad);
    assign CPU_CLR  = (r_state == StRun);
    assign LOADED   = (r_state == StRun);
    assign BUSY     = (r_state == StLoad) || (r_state == StFill) || (r_state == StRelease);
    assign COUNT    = r_count;

endmodule

// File: tb/tb_progmem_loader.sv
module tb_progmem_loader;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [3:0] A;
    logic [7:0] D;
    logic       LD_START;
    logic       LD_VALID;
    logic [7:0] LD_DATA;
    logic       LD_LAST;
    logic       LD_READY;
    logic       CPU_CLR;
    logic       BUSY;
    logic       LOADED;
    logic [4:0] COUNT;

    progmem_loader #(
        .RELEASE_CYCLES(2),
        .FILL_BYTE     (8'h00)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .A       (A),
        .D       (D),
        .LD_START(LD_START),
        .LD_VALID(LD_VALID),
        .LD_DATA (LD_DATA),
        .LD_LAST (LD_LAST),
        .LD_READY(LD_READY),
        .CPU_CLR (CPU_CLR),
        .BUSY    (BUSY),
        .LOADED  (LOADED),
        .COUNT   (COUNT)
    );

    always #5 CLK = ~CLK;

    localparam int SigD = 0, SigCpu = 1, SigLoaded = 2, SigReady = 3, SigBusy = 4, SigCount = 5;

    typedef struct {
        string      name;
        int         sig;
        logic [7:0] exp;
    } chk_t;

    chk_t chk_q[$];
    int   rel_cyc_q[$];
    int   rel_cnt_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: samples 2 time units after the falling edge, when both the
    // registered outputs and D (for the A driven at that edge) are settled.
    chk_t       it;
    logic [7:0] got;
    logic       prev_cpu = 1'b0;
    int         exp_cyc, exp_cnt;

    always @(negedge CLK) begin
        #2;
        while (chk_q.size() > 0) begin
            it = chk_q.pop_front();
            case (it.sig)
                SigD:      got = D;
                SigCpu:    got = {7'd0, CPU_CLR};
                SigLoaded: got = {7'd0, LOADED};
                SigReady:  got = {7'd0, LD_READY};
                SigBusy:   got = {7'd0, BUSY};
                default:   got = {3'd0, COUNT};
            endcase
            n_tests++;
            if (got !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h", it.name, got, it.exp);
            end
        end
        if (CPU_CLR === 1'b1 && prev_cpu == 1'b0) begin
            n_tests++;
            if (rel_cyc_q.size() == 0) begin
                n_fail++;
                $display("FAIL release: unexpected CPU_CLR rise at edge %0d", cyc);
            end else begin
                exp_cyc = rel_cyc_q.pop_front();
                exp_cnt = rel_cnt_q.pop_front();
                if (cyc != exp_cyc) begin
                    n_fail++;
                    $display("FAIL release_edge: got edge %0d, required edge %0d", cyc, exp_cyc);
                end
                n_tests++;
                if ({27'd0, COUNT} != exp_cnt || LOADED !== 1'b1 || BUSY !== 1'b0) begin
                    n_fail++;
                    $display("FAIL release_state: got COUNT=%0d LOADED=%b BUSY=%b, required %0d 1 0",
                             COUNT, LOADED, BUSY, exp_cnt);
                end
            end
        end
        prev_cpu = (CPU_CLR === 1'b1);
    end

    task automatic expect_sig(input string name, input int sig, input logic [7:0] exp);
        chk_t c;
        c.name = name;
        c.sig  = sig;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_idle(input string name);
        expect_sig({name, "_cpu"}, SigCpu, 8'd0);
        expect_sig({name, "_loaded"}, SigLoaded, 8'd0);
        expect_sig({name, "_ready"}, SigReady, 8'd0);
        expect_sig({name, "_busy"}, SigBusy, 8'd0);
        expect_sig({name, "_count"}, SigCount, 8'd0);
    endtask

    // Drive A and check D; one address per falling edge.
    task automatic read_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        A = a;
        expect_sig(name, SigD, exp);
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        LD_START = 1'b1;
        @(negedge CLK);
        LD_START = 1'b0;
    endtask

    // Present one byte; waits (bounded) for LD_READY. Returns at the falling
    // edge after the accepting rising edge.
    task automatic send(input logic [7:0] b, input logic last);
        int w = 0;
        while (LD_READY !== 1'b1 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        n_tests++;
        if (w >= 20) begin
            n_fail++;
            $display("FAIL send_ready: got LD_READY=%b, required 1", LD_READY);
        end
        LD_VALID = 1'b1;
        LD_DATA  = b;
        LD_LAST  = last;
        @(negedge CLK);
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        LD_DATA  = 8'hEE;
    endtask

    task automatic wait_run(input string name);
        int w = 0;
        while (CPU_CLR !== 1'b1 && w < 60) begin
            @(negedge CLK);
            w++;
        end
        n_tests++;
        if (w >= 60) begin
            n_fail++;
            $display("FAIL %s_timeout: got CPU_CLR=%b, required 1", name, CPU_CLR);
        end
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    int s, e;
    logic [7:0] bp_exp [4];

    initial begin
        CLR      = 1'b1;
        A        = 4'd0;
        LD_START = 1'b0;
        LD_VALID = 1'b0;
        LD_DATA  = 8'hEE;
        LD_LAST  = 1'b0;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;

        // Reset state and fill contents.
        expect_idle("reset");
        for (int i = 0; i < 16; i++) read_chk("reset_mem", 4'(i), 8'h00);

        // Full 16-byte load, continuous valid.
        pulse_start();
        s = cyc;
        rel_cyc_q.push_back(s + 18);
        rel_cnt_q.push_back(16);
        expect_sig("full_ready", SigReady, 8'd1);
        expect_sig("full_busy", SigBusy, 8'd1);
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0);
        wait_run("full");
        expect_sig("full_count", SigCount, 8'd16);
        expect_sig("full_loaded", SigLoaded, 8'd1);
        expect_sig("full_busy_run", SigBusy, 8'd0);
        read_chk("full_d5", 4'd5, 8'h15);
        read_chk("full_d15", 4'd15, 8'h1F);
        read_chk("full_d0", 4'd0, 8'h10);

        // Short load: 3 bytes then zero fill of 3..15.
        pulse_start();
        send(8'h31, 1'b0);
        send(8'h42, 1'b0);
        send(8'h53, 1'b1);
        e = cyc;
        rel_cyc_q.push_back(e + 15);
        rel_cnt_q.push_back(3);
        expect_sig("short_ready_fill", SigReady, 8'd0);
        expect_sig("short_busy_fill", SigBusy, 8'd1);
        wait_run("short");
        expect_sig("short_count", SigCount, 8'd3);
        read_chk("short_d0", 4'd0, 8'h31);
        read_chk("short_d1", 4'd1, 8'h42);
        read_chk("short_d2", 4'd2, 8'h53);
        for (int i = 3; i < 16; i++) read_chk("short_fill", 4'(i), 8'h00);

        // Back-pressure: valid every other cycle, junk EE in between.
        bp_exp[0] = 8'hA1;
        bp_exp[1] = 8'hB2;
        bp_exp[2] = 8'hC3;
        bp_exp[3] = 8'hD4;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(bp_exp[i], i == 3);
            if (i != 3) @(negedge CLK);
        end
        e = cyc;
        rel_cyc_q.push_back(e + 14);
        rel_cnt_q.push_back(4);
        wait_run("bp");
        expect_sig("bp_count", SigCount, 8'd4);
        for (int i = 0; i < 4; i++) read_chk("bp_data", 4'(i), bp_exp[i]);
        for (int i = 4; i < 16; i++) read_chk("bp_fill", 4'(i), 8'h00);

        // Reload from RUN; LD_START during LOAD is ignored.
        pulse_start();
        expect_sig("reload_cpu", SigCpu, 8'd0);
        expect_sig("reload_loaded", SigLoaded, 8'd0);
        expect_sig("reload_ready", SigReady, 8'd1);
        send(8'h60, 1'b0);
        send(8'h61, 1'b0);
        pulse_start();
        LD_START = 1'b1;
        send(8'h62, 1'b0);
        LD_START = 1'b0;
        expect_sig("reload_count_kept", SigCount, 8'd3);
        expect_sig("reload_still_load", SigReady, 8'd1);
        send(8'h63, 1'b1);
        e = cyc;
        rel_cyc_q.push_back(e + 14);
        rel_cnt_q.push_back(4);
        wait_run("reload");
        read_chk("reload_d0", 4'd0, 8'h60);
        read_chk("reload_d2", 4'd2, 8'h62);
        read_chk("reload_d3", 4'd3, 8'h63);
        read_chk("reload_d4", 4'd4, 8'h00);

        // Reset mid-load after 5 bytes; then CLR together with LD_START.
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 1'b0);
        CLR      = 1'b1;
        LD_VALID = 1'b1;
        LD_DATA  = 8'h99;
        @(negedge CLK);
        LD_VALID = 1'b0;
        LD_START = 1'b1;
        expect_idle("midclr");
        @(negedge CLK);
        expect_idle("clr_wins");
        for (int i = 0; i < 16; i++) read_chk("midclr_mem", 4'(i), 8'h00);
        CLR      = 1'b0;
        LD_START = 1'b0;
        @(negedge CLK);
        expect_idle("after_clr");
        repeat (3) @(negedge CLK);

        n_tests++;
        if (rel_cyc_q.size() != 0) begin
            n_fail++;
            $display("FAIL release_pending: got %0d unseen releases, required 0", rel_cyc_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
